// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard receiver: synchronizes and deglitches the keyboard clock,
// deframes 11-bit frames (start, 8 data LSB first, odd parity, stop) and
// tracks the held state of six game keys from make/break/extended codes.
module ps2_key_decoder #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       CLOCK_50,
  input  logic       KEY0,
  input  logic       PS2_CLK,
  input  logic       PS2_DAT,
  output logic [5:0] key_status_out,
  output logic [7:0] scan_code,
  output logic       scan_valid,
  output logic       frame_err
);

  localparam int FILT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam int TO_W   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  state_t            state, state_nxt;
  logic              ps2c_s1, ps2c_s2, ps2d_s1, ps2d_s2;
  logic              filt_clk;
  logic [FILT_W-1:0] flt_cnt;
  logic              flt_done;
  logic              fall;
  logic [TO_W-1:0]   to_cnt;
  logic [2:0]        bit_cnt;
  logic [7:0]        shift_q;
  logic              par_q;
  logic              ext_q, brk_q;
  logic              frame_ok, frame_bad, timeout;
  logic [5:0]        key_hit;

  // Two-flop synchronizers; idle bus level is high.
  always_ff @(posedge CLOCK_50 or negedge KEY0) begin
    if (!KEY0) begin
      ps2c_s1 <= 1'b1;
      ps2c_s2 <= 1'b1;
      ps2d_s1 <= 1'b1;
      ps2d_s2 <= 1'b1;
    end else begin
      ps2c_s1 <= PS2_CLK;
      ps2c_s2 <= ps2c_s1;
      ps2d_s1 <= PS2_DAT;
      ps2d_s2 <= ps2d_s1;
    end
  end

  // The filtered level flips on the FILTER_LEN-th consecutive differing sample;
  // a flip from 1 to 0 is the falling edge that clocks the data line.
  assign flt_done = (ps2c_s2 != filt_clk) && (flt_cnt == FILT_W'(FILTER_LEN - 1));
  assign fall     = flt_done && filt_clk;

  // Clock glitch filter.
  always_ff @(posedge CLOCK_50 or negedge KEY0) begin
    if (!KEY0) begin
      filt_clk <= 1'b1;
      flt_cnt  <= '0;
    end else if (ps2c_s2 == filt_clk || flt_done) begin
      flt_cnt  <= '0;
      if (flt_done) filt_clk <= ps2c_s2;
    end else begin
      flt_cnt  <= flt_cnt + 1'b1;
    end
  end

  // Frame FSM state register.
  always_ff @(posedge CLOCK_50 or negedge KEY0) begin
    if (!KEY0) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next state plus frame verdicts; an idle gap inside a frame overrides all.
  always_comb begin
    state_nxt = state;
    frame_ok  = 1'b0;
    frame_bad = 1'b0;
    timeout   = 1'b0;
    case (state)
      IDLE:   if (fall && !ps2d_s2) state_nxt = DATA;
      DATA:   if (fall && bit_cnt == 3'd7) state_nxt = PARITY;
      PARITY: if (fall) state_nxt = STOP;
      STOP: begin
        if (fall) begin
          state_nxt = IDLE;
          if (ps2d_s2 && ^{shift_q, par_q}) frame_ok  = 1'b1;
          else                              frame_bad = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (state != IDLE && !fall && to_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
      timeout   = 1'b1;
      state_nxt = IDLE;
    end
  end

  // Receive datapath and inter-edge watchdog.
  always_ff @(posedge CLOCK_50 or negedge KEY0) begin
    if (!KEY0) begin
      bit_cnt <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      to_cnt  <= '0;
    end else begin
      to_cnt <= (state == IDLE || fall) ? '0 : to_cnt + 1'b1;
      if (fall) begin
        case (state)
          IDLE:   bit_cnt <= '0;
          DATA: begin
            shift_q <= {ps2d_s2, shift_q[7:1]};
            bit_cnt <= bit_cnt + 1'b1;
          end
          PARITY: par_q <= ps2d_s2;
          default: ;
        endcase
      end
    end
  end

  // Which tracked key, if any, the received byte names under the current prefix.
  always_comb begin
    key_hit = '0;
    case (shift_q)
      8'h75:   key_hit[0] = ext_q;
      8'h6B:   key_hit[1] = ext_q;
      8'h72:   key_hit[2] = ext_q;
      8'h74:   key_hit[3] = ext_q;
      8'h29:   key_hit[4] = !ext_q;
      8'h5A:   key_hit[5] = 1'b1;
      default: ;
    endcase
  end

  // Outputs, prefix flags and held-key state; pulses are one cycle wide.
  always_ff @(posedge CLOCK_50 or negedge KEY0) begin
    if (!KEY0) begin
      key_status_out <= '0;
      scan_code      <= '0;
      scan_valid     <= 1'b0;
      frame_err      <= 1'b0;
      ext_q          <= 1'b0;
      brk_q          <= 1'b0;
    end else begin
      scan_valid <= 1'b0;
      frame_err  <= 1'b0;
      if (frame_ok) begin
        scan_code  <= shift_q;
        scan_valid <= 1'b1;
        if (shift_q == 8'hE0) begin
          ext_q <= 1'b1;
        end else if (shift_q == 8'hF0) begin
          brk_q <= 1'b1;
        end else begin
          ext_q <= 1'b0;
          brk_q <= 1'b0;
          key_status_out <= brk_q ? (key_status_out & ~key_hit)
                                  : (key_status_out | key_hit);
        end
      end else if (frame_bad || timeout) begin
        frame_err <= 1'b1;
        ext_q     <= 1'b0;
        brk_q     <= 1'b0;
      end
    end
  end

endmodule
